// File: rtl/gpr_regfile.sv
// ----------------------------------------------------------------------------
// gpr_regfile
//
// General-purpose register file for the core. Two combinational read ports
// and one synchronous write port, with optional write-to-read bypass and an
// optional hardwired-zero register 0.
//
// The storage array has no reset. After rst_n is released an init sequencer
// clears one register per clock. init_done rises on the edge that clears the
// last register, so it goes high NUM_REGS edges after reset is released.
// Until then every read port returns 0 and every write is dropped.
//
// Ports
//   clk        in   1           system clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   wen        in   1           write enable
//   waddr      in   ADDR_WIDTH  write register index
//   wdata      in   DATA_WIDTH  write data
//   raddr0     in   ADDR_WIDTH  read port 0 index
//   rdata0     out  DATA_WIDTH  read port 0 data
//   raddr1     in   ADDR_WIDTH  read port 1 index
//   rdata1     out  DATA_WIDTH  read port 1 data
//   init_done  out  1           all registers cleared, file usable
//
// Init sequencer states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | clearing register[cnt_q] each edge, writes and reads blocked
//   ST_RUN  | normal operation, held until rst_n is asserted
// ----------------------------------------------------------------------------
module gpr_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  init_done
);

   localparam int NUM_RD_PORTS = 2;

   // Index width into the implemented array; also the init counter width,
   // which only has to reach NUM_REGS-1.
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [IDX_W-1:0]    CNT_LAST = IDX_W'(NUM_REGS - 1);
   // One extra bit so NUM_REGS == 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] NREGS_W  = (ADDR_WIDTH + 1)'(NUM_REGS);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic                  run;
   logic                  waddr_ok;
   logic                  wr_ok;

   logic [ADDR_WIDTH-1:0] raddr_v [NUM_RD_PORTS];
   logic [DATA_WIDTH-1:0] rdata_v [NUM_RD_PORTS];

   // -------------------------------------------------------------------------
   // Init sequencer
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      case (state_q)
         ST_INIT: begin
            if (cnt_q == CNT_LAST) begin
               // Last register is cleared on this edge; counter parks here.
               state_d = ST_RUN;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   assign run       = (state_q == ST_RUN);
   assign init_done = done_q;

   // -------------------------------------------------------------------------
   // Write qualification
   // -------------------------------------------------------------------------
   assign waddr_ok = ({1'b0, waddr} < NREGS_W) &&
                     !((ZERO_REG != 0) && (waddr == '0));
   assign wr_ok    = run && wen && waddr_ok;

   // -------------------------------------------------------------------------
   // Storage: no reset. The sequencer clears it instead, so the array maps
   // onto plain enable flops or a memory macro.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         regs[cnt_q] <= '0;
      end else if (wr_ok) begin
         regs[waddr[IDX_W-1:0]] <= wdata;
      end
   end

   // -------------------------------------------------------------------------
   // Read ports
   // -------------------------------------------------------------------------
   assign raddr_v[0] = raddr0;
   assign raddr_v[1] = raddr1;

   always_comb begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         rdata_v[p] = '0;
         // Out-of-range and hardwired-zero addresses fall through to 0. A
         // qualified write can never target them, so the bypass check below
         // needs no extra range term.
         if (done_q && ({1'b0, raddr_v[p]} < NREGS_W) &&
             !((ZERO_REG != 0) && (raddr_v[p] == '0))) begin
            if ((BYPASS != 0) && wr_ok && (waddr == raddr_v[p])) begin
               rdata_v[p] = wdata;
            end else begin
               rdata_v[p] = regs[raddr_v[p][IDX_W-1:0]];
            end
         end
      end
   end

   assign rdata0 = rdata_v[0];
   assign rdata1 = rdata_v[1];

endmodule

// File: tb/tb_gpr_regfile.sv
// ----------------------------------------------------------------------------
// tb_gpr_regfile
//
// Directed bench for gpr_regfile. Three instances share one stimulus:
//   u_dut    defaults (32 regs, ZERO_REG=1, BYPASS=1)
//   u_nobyp  32 regs, ZERO_REG=1, BYPASS=0
//   u_r24    24 regs, ZERO_REG=0, BYPASS=1 (write enable gated by en_r24)
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after that.
// ----------------------------------------------------------------------------
module tb_gpr_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr0;
   logic [4:0]  raddr1;
   logic        en_r24;

   logic [31:0] d_rdata0, d_rdata1;
   logic [31:0] n_rdata0, n_rdata1;
   logic [31:0] r_rdata0, r_rdata1;
   logic        d_done, n_done, r_done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   gpr_regfile u_dut (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr0(raddr0), .rdata0(d_rdata0), .raddr1(raddr1), .rdata1(d_rdata1),
      .init_done(d_done)
   );

   gpr_regfile #(.BYPASS(0)) u_nobyp (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr0(raddr0), .rdata0(n_rdata0), .raddr1(raddr1), .rdata1(n_rdata1),
      .init_done(n_done)
   );

   gpr_regfile #(.NUM_REGS(24), .ZERO_REG(0)) u_r24 (
      .clk(clk), .rst_n(rst_n), .wen(wen & en_r24), .waddr(waddr),
      .wdata(wdata), .raddr0(raddr0), .rdata0(r_rdata0), .raddr1(raddr1),
      .rdata1(r_rdata1), .init_done(r_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wen   = 1'b1;
      waddr = a;
      wdata = d;
      tick();
      wen   = 1'b0;
   endtask

   // Counts rising edges until each instance raises init_done (0 = never).
   task automatic wait_init(output int e_d, output int e_n, output int e_r);
      e_d = 0; e_n = 0; e_r = 0;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (d_done && e_d == 0) e_d = n;
         if (n_done && e_n == 0) e_n = n;
         if (r_done && e_r == 0) e_r = n;
         if (e_d != 0 && e_n != 0 && e_r != 0) break;
      end
   endtask

   task automatic sweep_zero(input string tag);
      for (int a = 0; a < 32; a++) begin
         raddr0 = 5'(a);
         raddr1 = 5'(31 - a);
         #1;
         chk({tag, "_d0"}, d_rdata0, 32'h0);
         chk({tag, "_d1"}, d_rdata1, 32'h0);
         chk({tag, "_n0"}, n_rdata0, 32'h0);
         chk({tag, "_r0"}, r_rdata0, 32'h0);
      end
   endtask

   int e_d, e_n, e_r;
   logic [31:0] exp_r;

   initial begin
      rst_n  = 1'b0;
      en_r24 = 1'b0;
      wen    = 1'b1;
      waddr  = 5'd3;
      wdata  = 32'hDEAD_BEEF;
      raddr0 = 5'd3;
      raddr1 = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_done_d", {31'b0, d_done}, 32'h0);
      chk("rst_done_r", {31'b0, r_done}, 32'h0);
      chk("rst_rd_d", d_rdata0, 32'h0);

      // 1: init with a write held on waddr=3 the whole time
      @(negedge clk);
      rst_n = 1'b1;
      wait_init(e_d, e_n, e_r);
      wen = 1'b0;
      chk("init_edges_d", 32'(e_d), 32'd32);
      chk("init_edges_n", 32'(e_n), 32'd32);
      chk("init_edges_r", 32'(e_r), 32'd24);
      sweep_zero("init_clr");
      en_r24 = 1'b1;

      // 2: register 0 is hardwired to zero on the default build
      wr(5'd0, 32'hFFFF_FFFF);
      wen = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
      raddr0 = 5'd0; raddr1 = 5'd5;
      #1;
      chk("w5_pre_nobyp", n_rdata1, 32'h0);
      tick();
      wen = 1'b0;
      #1;
      chk("zero_reg_d", d_rdata0, 32'h0);
      chk("zero_reg_n", n_rdata0, 32'h0);
      chk("w5_d", d_rdata1, 32'h1234_5678);
      chk("w5_n", n_rdata1, 32'h1234_5678);
      chk("r24_reg0", r_rdata0, 32'hFFFF_FFFF);

      // 3: same-cycle write and read of register 7
      wr(5'd7, 32'h0000_0011);
      wen = 1'b1; waddr = 5'd7; wdata = 32'h0000_0022;
      raddr0 = 5'd7; raddr1 = 5'd7;
      #1;
      chk("byp_d0", d_rdata0, 32'h22);
      chk("byp_d1", d_rdata1, 32'h22);
      chk("nobyp_old0", n_rdata0, 32'h11);
      chk("nobyp_old1", n_rdata1, 32'h11);
      tick();
      wen = 1'b0;
      #1;
      chk("nobyp_new0", n_rdata0, 32'h22);
      chk("nobyp_new1", n_rdata1, 32'h22);
      chk("byp_after", d_rdata0, 32'h22);

      // ignored write to register 0 must not bypass
      en_r24 = 1'b0;
      wen = 1'b1; waddr = 5'd0; wdata = 32'h0000_0099;
      raddr0 = 5'd0; raddr1 = 5'd5;
      #1;
      chk("byp_ign_r0", d_rdata0, 32'h0);
      chk("byp_ign_r1", d_rdata1, 32'h1234_5678);
      tick();
      wen = 1'b0;
      en_r24 = 1'b1;
      #1;
      chk("ign_r0_after", d_rdata0, 32'h0);

      // 4: out-of-range write on the 24-register build
      wen = 1'b1; waddr = 5'd30; wdata = 32'h0000_ABCD;
      raddr0 = 5'd30; raddr1 = 5'd30;
      #1;
      chk("oor_byp_r24", r_rdata0, 32'h0);
      chk("oor_byp_r24_1", r_rdata1, 32'h0);
      chk("r30_byp_d", d_rdata0, 32'h0000_ABCD);
      chk("r30_old_n", n_rdata0, 32'h0);
      tick();
      wen = 1'b0;
      #1;
      chk("oor_after_r24", r_rdata0, 32'h0);
      chk("r30_new_n", n_rdata0, 32'h0000_ABCD);
      for (int a = 0; a < 32; a++) begin
         raddr0 = 5'(a);
         raddr1 = 5'(a);
         #1;
         case (a)
            0:       exp_r = 32'hFFFF_FFFF;
            5:       exp_r = 32'h1234_5678;
            7:       exp_r = 32'h0000_0022;
            default: exp_r = 32'h0;
         endcase
         chk("r24_keep0", r_rdata0, exp_r);
         chk("r24_keep1", r_rdata1, exp_r);
      end

      // 5: fill, then reset mid-operation
      for (int a = 1; a < 32; a++) wr(5'(a), 32'(a));
      raddr0 = 5'd31; raddr1 = 5'd17;
      #1;
      chk("fill31_d", d_rdata0, 32'd31);
      chk("fill17_d", d_rdata1, 32'd17);
      chk("fill31_n", n_rdata0, 32'd31);
      chk("fill17_r", r_rdata1, 32'd17);
      rst_n = 1'b0;
      #1;
      chk("rst_fall_d", {31'b0, d_done}, 32'h0);
      chk("rst_fall_r", {31'b0, r_done}, 32'h0);
      chk("rst_rd_31", d_rdata0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_init(e_d, e_n, e_r);
      chk("reinit_edges_d", 32'(e_d), 32'd32);
      chk("reinit_edges_r", 32'(e_r), 32'd24);
      sweep_zero("reinit_clr");

      // reset again partway through INIT
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) tick();
      chk("mid_init_low", {31'b0, d_done}, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_done", {31'b0, d_done}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_init(e_d, e_n, e_r);
      chk("restart_edges_d", 32'(e_d), 32'd32);
      chk("restart_edges_n", 32'(e_n), 32'd32);
      chk("restart_edges_r", 32'(e_r), 32'd24);
      sweep_zero("restart_clr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
